// File: rtl/ext_mem_pkg.sv
// Shared types for the external memory arbiter: request payload layout and
// the requester ID carried in the response tag FIFO.
package ext_mem_pkg;

  localparam int MEM_W = 68;

  typedef struct packed {
    logic [3:0]  byte_en;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_FETCH = 1'b0;
  localparam req_id_t REQ_LSU   = 1'b1;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester IDs. One entry per issued memory request;
// the head entry names the requester that owns the next memory response.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  slots_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = slots_q[head_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    doPush  = push_i & ~full_o;
    doPop   = pop_i & ~empty_o;
    head_d  = doPop  ? head_q + AW'(1) : head_q;
    tail_d  = doPush ? tail_q + AW'(1) : tail_q;
    count_d = count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        slots_q[tail_q] <= data_i;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Shares one ext_mem port between instruction fetch (requester 0) and
// load/store (requester 1) with round-robin issue and in-order response steering.
module ext_mem_arbiter #(
  parameter int MEM_W = 68,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             r0_req_valid,
  input  logic [MEM_W-1:0] r0_req,
  output logic             r0_req_ready,
  input  logic             r1_req_valid,
  input  logic [MEM_W-1:0] r1_req,
  output logic             r1_req_ready,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [MEM_W-1:0] rsp,
  output logic             mem_put_enable,
  input  logic             mem_put_ready,
  output logic [MEM_W-1:0] mem_put_request,
  output logic             mem_get_enable,
  input  logic             mem_get_ready,
  input  logic [MEM_W-1:0] mem_get_response
);

  import ext_mem_pkg::*;

  req_id_t lastGrant_q, lastGrant_d;
  req_id_t winner;
  req_id_t headId;
  logic    fifoFull, fifoEmpty;
  logic    issue, route, getEnable;

  // Outputs are held low during the reset cycle, whatever the inputs do.
  always_comb begin
    if (r0_req_valid && r1_req_valid) begin
      winner = ~lastGrant_q;
    end else begin
      winner = r1_req_valid ? REQ_LSU : REQ_FETCH;
    end
    issue       = ~RST & mem_put_ready & ~fifoFull & (r0_req_valid | r1_req_valid);
    route       = ~RST & mem_get_ready & ~fifoEmpty;
    getEnable   = route & ((headId == REQ_LSU) ? r1_rsp_ready : r0_rsp_ready);
    lastGrant_d = issue ? winner : lastGrant_q;
  end

  assign r0_req_ready    = issue & (winner == REQ_FETCH);
  assign r1_req_ready    = issue & (winner == REQ_LSU);
  assign mem_put_enable  = issue;
  assign mem_put_request = issue ? ((winner == REQ_LSU) ? r1_req : r0_req) : '0;

  assign r0_rsp_valid    = route & (headId == REQ_FETCH);
  assign r1_rsp_valid    = route & (headId == REQ_LSU);
  assign rsp             = route ? mem_get_response : '0;
  assign mem_get_enable  = getEnable;

  // Starting at LSU makes fetch win the first tie after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lastGrant_q <= REQ_LSU;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

  tag_fifo #(
    .DEPTH(DEPTH),
    .W    (1)
  ) u_tag_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (issue),
    .pop_i  (getEnable),
    .data_i (winner),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .head_o (headId)
  );

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter: directed scenarios with literal
// expectations followed by randomized traffic checked against a queue model.
module tb_ext_mem_arbiter;

  import ext_mem_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             r0v = 1'b0, r1v = 1'b0;
  logic [MEM_W-1:0] r0Req = '0, r1Req = '0;
  logic             r0Rdy, r1Rdy;
  logic             r0RspV, r1RspV;
  logic             rr0 = 1'b0, rr1 = 1'b0;
  logic [MEM_W-1:0] rspOut;
  logic             putEn, putReady = 1'b0;
  logic [MEM_W-1:0] putReq;
  logic             getEn, getReady = 1'b0;
  logic [MEM_W-1:0] getResp = '0;

  int passCount  = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  ext_mem_arbiter #(.MEM_W(MEM_W), .DEPTH(DEPTH)) dut (
    .CLK             (clk),
    .RST             (rst),
    .r0_req_valid    (r0v),
    .r0_req          (r0Req),
    .r0_req_ready    (r0Rdy),
    .r1_req_valid    (r1v),
    .r1_req          (r1Req),
    .r1_req_ready    (r1Rdy),
    .r0_rsp_valid    (r0RspV),
    .r0_rsp_ready    (rr0),
    .r1_rsp_valid    (r1RspV),
    .r1_rsp_ready    (rr1),
    .rsp             (rspOut),
    .mem_put_enable  (putEn),
    .mem_put_ready   (putReady),
    .mem_put_request (putReq),
    .mem_get_enable  (getEn),
    .mem_get_ready   (getReady),
    .mem_get_response(getResp)
  );

  task automatic checkOutput(input string name, input logic [MEM_W-1:0] act,
                             input logic [MEM_W-1:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [MEM_W-1:0] mkReq(input logic [31:0] addr, input logic [31:0] data);
    mem_req_t r;
    r.byte_en = 4'hF;
    r.addr    = addr;
    r.data    = data;
    return r;
  endfunction

  function automatic logic [MEM_W-1:0] rndReq();
    mem_req_t r;
    r.byte_en = 4'($urandom_range(15));
    r.addr    = $urandom;
    r.data    = $urandom;
    return r;
  endfunction

  // Inputs change 1 time unit after the rising edge; checks happen just after the falling edge.
  task automatic applyStimulus(input bit rstIn, input bit v0, input bit v1,
                               input logic [MEM_W-1:0] q0, input logic [MEM_W-1:0] q1,
                               input bit putR, input bit getR, input bit ready0,
                               input bit ready1, input logic [MEM_W-1:0] resp);
    @(posedge clk);
    #1;
    rst = rstIn; r0v = v0; r1v = v1; r0Req = q0; r1Req = q1;
    putReady = putR; getReady = getR; rr0 = ready0; rr1 = ready1; getResp = resp;
    @(negedge clk);
    #1;
  endtask

  // Reference model: a queue of outstanding requester IDs plus the last granted ID.
  bit               tagQ[$];
  bit               lastGrant = 1'b1;
  bit               mIssue, mRoute, mWin, mHead, mGetEn;
  logic [MEM_W-1:0] mPut, mRsp;

  always @(negedge clk) begin
    mWin   = (r0v && r1v) ? !lastGrant : r1v;
    mHead  = (tagQ.size() > 0) ? tagQ[0] : 1'b0;
    mIssue = !rst && putReady && (tagQ.size() < DEPTH) && (r0v || r1v);
    mRoute = !rst && getReady && (tagQ.size() > 0);
    mGetEn = mRoute && (mHead ? rr1 : rr0);
    mPut   = mIssue ? (mWin ? r1Req : r0Req) : '0;
    mRsp   = mRoute ? getResp : '0;
    checkOutput("r0_req_ready", MEM_W'(r0Rdy), MEM_W'(mIssue && !mWin));
    checkOutput("r1_req_ready", MEM_W'(r1Rdy), MEM_W'(mIssue && mWin));
    checkOutput("mem_put_enable", MEM_W'(putEn), MEM_W'(mIssue));
    checkOutput("mem_put_request", putReq, mPut);
    checkOutput("r0_rsp_valid", MEM_W'(r0RspV), MEM_W'(mRoute && !mHead));
    checkOutput("r1_rsp_valid", MEM_W'(r1RspV), MEM_W'(mRoute && mHead));
    checkOutput("rsp", rspOut, mRsp);
    checkOutput("mem_get_enable", MEM_W'(getEn), MEM_W'(mGetEn));
    if (rst) begin
      tagQ.delete();
      lastGrant = 1'b1;
    end else begin
      if (mGetEn) void'(tagQ.pop_front());
      if (mIssue) begin
        tagQ.push_back(mWin);
        lastGrant = mWin;
      end
    end
  end

  logic [MEM_W-1:0] z;
  logic [MEM_W-1:0] respA;

  initial begin
    z     = '0;
    respA = mkReq(32'h0, 32'h0000_AAAA);

    // Reset with a pending request: nothing may issue.
    applyStimulus(1, 1, 0, mkReq(32'h100, 32'h1), z, 1, 0, 0, 0, z);
    checkOutput("rstPutEn", MEM_W'(putEn), '0);
    checkOutput("rstReady0", MEM_W'(r0Rdy), '0);

    // First fetch request, then its response one cycle later.
    applyStimulus(0, 1, 0, mkReq(32'h100, 32'h1), z, 1, 0, 0, 0, z);
    checkOutput("firstReady0", MEM_W'(r0Rdy), MEM_W'(1));
    checkOutput("firstReady1", MEM_W'(r1Rdy), '0);
    checkOutput("firstAddr", MEM_W'(putReq[63:32]), MEM_W'(32'h100));
    applyStimulus(0, 0, 0, z, z, 1, 1, 1, 1, respA);
    checkOutput("firstRspV0", MEM_W'(r0RspV), MEM_W'(1));
    checkOutput("firstRspV1", MEM_W'(r1RspV), '0);
    checkOutput("firstRsp", rspOut, respA);
    checkOutput("firstGetEn", MEM_W'(getEn), MEM_W'(1));

    // Back-to-back ties alternate starting with fetch; responses follow in issue order.
    applyStimulus(1, 0, 0, z, z, 0, 0, 0, 0, z);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 1, mkReq(32'h200 + k, 32'h0), mkReq(32'h300 + k, 32'h0), 1, 1, 1, 1, respA);
      checkOutput("tieReady0", MEM_W'(r0Rdy), MEM_W'(k % 2 == 0));
      checkOutput("tieReady1", MEM_W'(r1Rdy), MEM_W'(k % 2 == 1));
      if (k > 0) begin
        checkOutput("tieRspV0", MEM_W'(r0RspV), MEM_W'(k % 2 == 1));
        checkOutput("tieRspV1", MEM_W'(r1RspV), MEM_W'(k % 2 == 0));
      end
    end
    applyStimulus(0, 0, 0, z, z, 1, 1, 1, 1, respA);
    checkOutput("drainRspV1", MEM_W'(r1RspV), MEM_W'(1));
    checkOutput("drainRspV0", MEM_W'(r0RspV), '0);

    // Fill the tag FIFO, then check full back-pressure including the pop-same-cycle case.
    applyStimulus(1, 0, 0, z, z, 0, 0, 0, 0, z);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(0, 1, 0, mkReq(32'h400 + k, 32'h0), z, 1, 0, 0, 0, z);
      checkOutput("fillReady0", MEM_W'(r0Rdy), MEM_W'(1));
    end
    applyStimulus(0, 1, 1, z, z, 1, 0, 1, 1, z);
    checkOutput("fullReady0", MEM_W'(r0Rdy), '0);
    checkOutput("fullReady1", MEM_W'(r1Rdy), '0);
    checkOutput("fullPutEn", MEM_W'(putEn), '0);
    applyStimulus(0, 1, 0, z, z, 1, 1, 1, 1, respA);
    checkOutput("fullPopGetEn", MEM_W'(getEn), MEM_W'(1));
    checkOutput("fullPopReady0", MEM_W'(r0Rdy), '0);
    applyStimulus(0, 1, 0, z, z, 1, 0, 1, 1, z);
    checkOutput("afterPopReady0", MEM_W'(r0Rdy), MEM_W'(1));

    // Empty FIFO ignores a stray response; then LSU head stalls on rsp_ready.
    applyStimulus(1, 0, 0, z, z, 0, 0, 0, 0, z);
    applyStimulus(0, 0, 0, z, z, 1, 1, 1, 1, respA);
    checkOutput("emptyGetEn", MEM_W'(getEn), '0);
    checkOutput("emptyRspV0", MEM_W'(r0RspV), '0);
    checkOutput("emptyRspV1", MEM_W'(r1RspV), '0);
    applyStimulus(0, 0, 1, z, mkReq(32'h500, 32'h5), 1, 0, 0, 0, z);
    checkOutput("lsuReady1", MEM_W'(r1Rdy), MEM_W'(1));
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, z, z, 1, 1, 1, 0, respA);
      checkOutput("stallRspV1", MEM_W'(r1RspV), MEM_W'(1));
      checkOutput("stallGetEn", MEM_W'(getEn), '0);
      checkOutput("stallRsp", rspOut, respA);
    end

    // Reset with requests in flight drops the tags and restores fetch priority.
    applyStimulus(1, 0, 0, z, z, 0, 0, 0, 0, z);
    applyStimulus(0, 1, 0, z, z, 1, 0, 0, 0, z);
    applyStimulus(0, 0, 1, z, z, 1, 0, 0, 0, z);
    applyStimulus(1, 1, 1, z, z, 1, 1, 1, 1, respA);
    checkOutput("midRstPutEn", MEM_W'(putEn), '0);
    checkOutput("midRstGetEn", MEM_W'(getEn), '0);
    applyStimulus(0, 1, 1, mkReq(32'h600, 32'h6), mkReq(32'h700, 32'h7), 1, 1, 1, 1, respA);
    checkOutput("postRstReady0", MEM_W'(r0Rdy), MEM_W'(1));
    checkOutput("postRstReady1", MEM_W'(r1Rdy), '0);
    checkOutput("postRstRspV0", MEM_W'(r0RspV), '0);
    checkOutput("postRstRspV1", MEM_W'(r1RspV), '0);

    // Randomized traffic with occasional resets, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(149) == 0,
                    1'($urandom_range(1)), 1'($urandom_range(1)),
                    rndReq(), rndReq(),
                    $urandom_range(3) != 0, $urandom_range(4) < 3,
                    $urandom_range(3) != 0, $urandom_range(3) != 0,
                    rndReq());
    end

    applyStimulus(0, 0, 0, z, z, 0, 0, 0, 0, z);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
